// File: rtl/debounce_edge_pkg.sv
// Shared definitions for the debounce/edge-detect block: FSM state encoding
// and default parameter values.
package debounce_edge_pkg;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_CNT_W         = 8;
  localparam int DEF_EVT_W         = 8;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

endpackage

// File: rtl/debounce_edge_sync_chain.sv
// Plain flop-chain synchroniser for asynchronous level inputs, reusable by
// other input-conditioning blocks.
module sync_chain
  import debounce_edge_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // No logic between stages, so metastability only has to resolve flop to flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Debounces a raw level input: synchronise, require STABLE_CYCLES consecutive
// samples at a new value, then emit a registered level, edge strobes and a rise count.
module debounce_edge
  import debounce_edge_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int EVT_W         = DEF_EVT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  output logic             q,
  output logic             rise,
  output logic             fall,
  output logic [EVT_W-1:0] evt_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = STABLE_CYCLES - 1;
  localparam logic [EVT_W-1:0] EVT_ONE  = 1;

  logic             d_sync;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (d_in),
    .q  (d_sync)
  );

  // The cycle that moves into S_RISE/S_FALL already counts as the first
  // stable sample, hence cnt <= 1 there and acceptance at STABLE_CYCLES-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_LOW;
      cnt     <= '0;
      q       <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      evt_cnt <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        S_LOW: begin
          if (d_sync) begin
            state <= S_RISE;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        S_RISE: begin
          if (!d_sync) begin
            state <= S_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= S_HIGH;
            cnt     <= '0;
            q       <= 1'b1;
            rise    <= 1'b1;
            evt_cnt <= evt_cnt + EVT_ONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!d_sync) begin
            state <= S_FALL;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        S_FALL: begin
          if (d_sync) begin
            state <= S_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= S_LOW;
            cnt   <= '0;
            q     <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: directed segment table plus randomized runs, all
// checked every cycle against a run-length reference model.
module tb_debounce_edge;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_in;
  logic       q, rise, fall;
  logic [7:0] evt_cnt;
  logic       q_w, rise_w, fall_w;
  logic [1:0] evt_cnt_w;

  int vectors = 0;
  int miscompares = 0;

  debounce_edge dut (
    .clk(clk), .rst(rst), .d_in(d_in),
    .q(q), .rise(rise), .fall(fall), .evt_cnt(evt_cnt)
  );

  debounce_edge #(.EVT_W(2)) dut_wrap (
    .clk(clk), .rst(rst), .d_in(d_in),
    .q(q_w), .rise(rise_w), .fall(fall_w), .evt_cnt(evt_cnt_w)
  );

  always #5 clk = ~clk;

  // Model: d_in reaches the filter SYNC edges late; q flips once the filter
  // has seen STABLE consecutive samples differing from q.
  bit pipe_m[$];
  bit q_m, rise_m, fall_m;
  int run_m, evt_m;

  task automatic modelReset();
    pipe_m.delete();
    for (int i = 0; i < SYNC; i++) pipe_m.push_back(1'b0);
    q_m = 0; rise_m = 0; fall_m = 0; run_m = 0; evt_m = 0;
  endtask

  task automatic modelStep(input bit r, input bit d);
    bit ds;
    if (r) begin
      modelReset();
      return;
    end
    ds = pipe_m.pop_front();
    pipe_m.push_back(d);
    rise_m = 0;
    fall_m = 0;
    if (ds != q_m) run_m++;
    else run_m = 0;
    if (run_m == STABLE) begin
      q_m = ds;
      run_m = 0;
      if (ds) begin
        rise_m = 1;
        evt_m++;
      end else begin
        fall_m = 1;
      end
    end
  endtask

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    compare("q", q, q_m);
    compare("rise", rise, rise_m);
    compare("fall", fall, fall_m);
    compare("evt_cnt", evt_cnt, evt_m % 256);
    compare("q_wrap", q_w, q_m);
    compare("evt_cnt_wrap", evt_cnt_w, evt_m % 4);
  endtask

  task automatic applyStimulus(input bit r, input bit d);
    rst  = r;
    d_in = d;
    @(posedge clk);
    modelStep(r, d);
    #1;
    checkOutput();
  endtask

  typedef struct {
    bit rst;
    bit d;
    int n;
    bit q;
    bit r;
    bit f;
    int evt;
    int evt2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r_i, bit d_i, int n_i, bit q_i, bit ri, bit fi, int e_i, int e2_i);
    vec_t v;
    v.rst = r_i; v.d = d_i; v.n = n_i; v.q = q_i;
    v.r = ri; v.f = fi; v.evt = e_i; v.evt2 = e2_i;
    return v;
  endfunction

  initial begin
    bit rd;
    bit rr;
    int len;
    rst  = 1'b1;
    d_in = 1'b0;
    modelReset();

    // Reset held with d_in high, then recovery and a 20-cycle press
    vecs.push_back(mk(1, 1, 3,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1,  1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 14, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 5,  1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1,  0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 8,  0, 0, 0, 1, 1));
    // STABLE-1 glitch rejected, STABLE glitch accepted
    vecs.push_back(mk(0, 1, 3,  0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 6,  0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 4,  0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1,  0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1,  1, 1, 0, 2, 2));
    vecs.push_back(mk(0, 0, 4,  0, 0, 1, 2, 2));
    vecs.push_back(mk(0, 0, 4,  0, 0, 0, 2, 2));
    // Bounce on release
    vecs.push_back(mk(0, 1, 6,  1, 1, 0, 3, 3));
    vecs.push_back(mk(0, 1, 4,  1, 0, 0, 3, 3));
    vecs.push_back(mk(0, 0, 1,  1, 0, 0, 3, 3));
    vecs.push_back(mk(0, 1, 1,  1, 0, 0, 3, 3));
    vecs.push_back(mk(0, 0, 1,  1, 0, 0, 3, 3));
    vecs.push_back(mk(0, 1, 1,  1, 0, 0, 3, 3));
    vecs.push_back(mk(0, 0, 5,  1, 0, 0, 3, 3));
    vecs.push_back(mk(0, 0, 1,  0, 0, 1, 3, 3));
    vecs.push_back(mk(0, 0, 4,  0, 0, 0, 3, 3));
    // Reset in the middle of the rise window
    vecs.push_back(mk(0, 1, 4,  0, 0, 0, 3, 3));
    vecs.push_back(mk(1, 1, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1,  1, 1, 0, 1, 1));
    // Five clean presses; the 2-bit counter wraps 1,2,3,0,1
    vecs.push_back(mk(1, 0, 1,  0, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) begin
      vecs.push_back(mk(0, 1, 6, 1, 1, 0, k, k % 4));
      vecs.push_back(mk(0, 0, 6, 0, 0, 1, k, k % 4));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) applyStimulus(vecs[i].rst, vecs[i].d);
      compare($sformatf("vec%0d.q", i), q, vecs[i].q);
      compare($sformatf("vec%0d.rise", i), rise, vecs[i].r);
      compare($sformatf("vec%0d.fall", i), fall, vecs[i].f);
      compare($sformatf("vec%0d.evt_cnt", i), evt_cnt, vecs[i].evt);
      compare($sformatf("vec%0d.evt_cnt_wrap", i), evt_cnt_w, vecs[i].evt2);
    end

    // Random runs of 1..8 cycles straddle the acceptance window
    for (int i = 0; i < 120; i++) begin
      rd  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        rr = ($urandom_range(0, 199) == 0);
        applyStimulus(rr, rd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
